// File: rtl/aes_key_sched_seq_if.sv
// Key-schedule engine bus: start/config inputs, status outputs and round-key read port.
// Pure wiring; no storage, so it adds no latency.
// Backpressure: none; the slave is always ready and flags misuse with cfg_err/rd_err.
interface aes_key_sched_seq_if #(parameter int MAX_NK = 8);
  logic                  start;
  logic [1:0]            key_len;
  logic [32*MAX_NK-1:0]  key_in;
  logic                  busy;
  logic                  done;
  logic                  rk_valid;
  logic                  cfg_err;
  logic                  rd_en;
  logic [3:0]            rd_round;
  logic                  rd_inv;
  logic [127:0]          rk_out;
  logic                  rk_out_valid;
  logic                  rd_err;

  modport slave (
    input  start, key_len, key_in, rd_en, rd_round, rd_inv,
    output busy, done, rk_valid, cfg_err, rk_out, rk_out_valid, rd_err
  );

  modport master (
    output start, key_len, key_in, rd_en, rd_round, rd_inv,
    input  busy, done, rk_valid, cfg_err, rk_out, rk_out_valid, rd_err
  );
endinterface

// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128/192/256 key expansion, one 32-bit word per cycle, plus a round-key read port.
// Latency: done pulses 4*(Nr+1)-Nk+1 cycles after start; a round-key read answers one cycle after rd_en.
// Backpressure: none; start is ignored outside IDLE, and a bad start or read gives an error pulse.

// Four-byte S-box bank: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox4 (
  input  logic [31:0] a_i,
  output logic [31:0] y_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the inverse of x (and maps 0 to 0); affine step then adds 0x63
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // substitute each byte independently
  always_comb begin
    y_o = '0;
    for (int b = 0; b < 4; b++) y_o[8*b +: 8] = sbox(a_i[8*b +: 8]);
  end
endmodule

module aes_key_sched_seq #(
  parameter int MAX_NK    = 8,
  parameter int BUF_WORDS = 4 * (MAX_NK + 7)
) (
  input logic               clk,
  input logic               rst_n,
  aes_key_sched_seq_if.slave bus
);
  localparam int              IW       = $clog2(BUF_WORDS);
  localparam logic [3:0]      MAX_NK_W = 4'(MAX_NK);
  localparam logic [1:0]      S_IDLE   = 2'd0;
  localparam logic [1:0]      S_EXPAND = 2'd1;
  localparam logic [1:0]      S_DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] i_q, i_d;        // index of the word being produced
  logic [3:0]    j_q, j_d;        // i mod Nk, tracked incrementally
  logic [3:0]    nk_q, nk_d;
  logic [3:0]    nr_q, nr_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rk_valid_q, rk_valid_d;
  logic          cfg_err_q, cfg_err_d;
  logic [127:0]  rk_out_q;
  logic          rk_out_valid_q;
  logic          rd_err_q;
  logic [31:0]   w_q [BUF_WORDS];

  logic [3:0]    nk_dec, nr_dec;
  logic          len_ok, accept;
  logic [31:0]   prev_w, back_w, sub_in, sub_out, new_w;
  logic [IW-1:0] last_idx;
  logic          rd_ok;
  logic [3:0]    rd_sel;
  logic [IW-1:0] rd_base;
  logic [127:0]  rd_word;

  // key length decode; lengths wider than the key port are treated as illegal
  always_comb begin
    nk_dec = 4'd4;
    nr_dec = 4'd10;
    case (bus.key_len)
      2'b01:   begin nk_dec = 4'd6; nr_dec = 4'd12; end
      2'b10:   begin nk_dec = 4'd8; nr_dec = 4'd14; end
      default: begin nk_dec = 4'd4; nr_dec = 4'd10; end
    endcase
    len_ok = (bus.key_len != 2'b11) && (nk_dec <= MAX_NK_W);
    accept = (state_q == S_IDLE) && bus.start && len_ok;
  end

  // select the S-box input: rotated previous word at a key-length boundary, else the word itself
  always_comb begin
    prev_w = w_q[i_q - IW'(1)];
    back_w = w_q[i_q - IW'(nk_q)];
    sub_in = (j_q == 4'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  end

  aes_sbox4 u_sbox (.a_i(sub_in), .y_o(sub_out));

  // form the next schedule word from w[i-Nk] and the transformed w[i-1]
  always_comb begin
    if (j_q == 4'd0)                          new_w = back_w ^ sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && j_q == 4'd4)     new_w = back_w ^ sub_out;
    else                                      new_w = back_w ^ prev_w;
    last_idx = IW'({nr_q, 2'b00}) + IW'(3);
  end

  // control FSM next state
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    rcon_d     = rcon_q;
    busy_d     = busy_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_EXPAND;
          nk_d       = nk_dec;
          nr_d       = nr_dec;
          i_d        = IW'(nk_dec);
          j_d        = 4'd0;
          rcon_d     = 8'h01;
          busy_d     = 1'b1;
          rk_valid_d = 1'b0;
        end else if (bus.start) begin
          cfg_err_d  = 1'b1;
        end
      end
      S_EXPAND: begin
        i_d = i_q + IW'(1);
        j_d = (j_q == nk_q - 4'd1) ? 4'd0 : j_q + 4'd1;
        if (j_q == 4'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (i_q == last_idx) begin
          state_d    = S_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          rk_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      nk_q       <= 4'd4;
      nr_q       <= 4'd10;
      rcon_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      rcon_q     <= rcon_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rk_valid_q <= rk_valid_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // word buffer: load the cipher key on start, then one expanded word per cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < MAX_NK; j++)
        if (4'(j) < nk_dec) w_q[j] <= bus.key_in[32*MAX_NK-1-32*j -: 32];
    end else if (state_q == S_EXPAND) begin
      w_q[i_q] <= new_w;
    end
  end

  // read address: forward or reversed round order against the latched Nr
  always_comb begin
    rd_ok   = rk_valid_q && (bus.rd_round <= nr_q);
    rd_sel  = bus.rd_inv ? (nr_q - bus.rd_round) : bus.rd_round;
    rd_base = IW'({rd_sel, 2'b00});
    rd_word = {w_q[rd_base], w_q[rd_base + IW'(1)], w_q[rd_base + IW'(2)], w_q[rd_base + IW'(3)]};
  end

  // registered read response; rk_out holds when idle, zeroes on an illegal read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out_q       <= '0;
      rk_out_valid_q <= 1'b0;
      rd_err_q       <= 1'b0;
    end else if (bus.rd_en && rd_ok) begin
      rk_out_q       <= rd_word;
      rk_out_valid_q <= 1'b1;
      rd_err_q       <= 1'b0;
    end else if (bus.rd_en) begin
      rk_out_q       <= '0;
      rk_out_valid_q <= 1'b0;
      rd_err_q       <= 1'b1;
    end else begin
      rk_out_valid_q <= 1'b0;
      rd_err_q       <= 1'b0;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.rk_valid     = rk_valid_q;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.rk_out       = rk_out_q;
  assign bus.rk_out_valid = rk_out_valid_q;
  assign bus.rd_err       = rd_err_q;
endmodule
